// File: rtl/apb_arbiter_2m.sv
// Two-requester APB arbiter: round-robin grant, one registered SETUP/ACCESS transfer downstream at a time.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_arbiter_2m #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    M0_PSEL,
    input  logic [ADDR_WIDTH-1:0]   M0_PADDR,
    input  logic [2:0]              M0_PPROT,
    input  logic                    M0_PWRITE,
    input  logic [DATA_WIDTH-1:0]   M0_PWDATA,
    input  logic [DATA_WIDTH/8-1:0] M0_PSTRB,
    output logic                    M0_PREADY,
    output logic [DATA_WIDTH-1:0]   M0_PRDATA,
    output logic                    M0_PSLVERR,
    input  logic                    M1_PSEL,
    input  logic [ADDR_WIDTH-1:0]   M1_PADDR,
    input  logic [2:0]              M1_PPROT,
    input  logic                    M1_PWRITE,
    input  logic [DATA_WIDTH-1:0]   M1_PWDATA,
    input  logic [DATA_WIDTH/8-1:0] M1_PSTRB,
    output logic                    M1_PREADY,
    output logic [DATA_WIDTH-1:0]   M1_PRDATA,
    output logic                    M1_PSLVERR,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [2:0]              PPROT,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PSEL,
    output logic                    PENABLE,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic                  last_grant;
    logic                  grant_vld, grant_sel;
    logic                  done, tmo, tmo_hit;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts ACCESS cycles without PREADY; cleared while in SETUP so it starts at 0 in ACCESS.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            tmo_cnt <= '0;
        else if (state == SETUP)
            tmo_cnt <= '0;
        else if (state == ACCESS && !PREADY)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_sel = last_grant;
        done      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (M0_PSEL || M1_PSEL) begin
                    grant_vld = 1'b1;
                    // Under contention the requester that did not win last time is chosen.
                    grant_sel = M1_PSEL && (!M0_PSEL || !last_grant);
                    state_nxt = SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    done      = 1'b1;
                    tmo       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_data = (tmo || PWRITE) ? '0 : PRDATA;
    assign rsp_err  = tmo || PSLVERR;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_grant <= 1'b1;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PADDR      <= '0;
            PPROT      <= '0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            PSTRB      <= '0;
            M0_PREADY  <= 1'b0;
            M0_PRDATA  <= '0;
            M0_PSLVERR <= 1'b0;
            M1_PREADY  <= 1'b0;
            M1_PRDATA  <= '0;
            M1_PSLVERR <= 1'b0;
        end else begin
            M0_PREADY <= 1'b0;
            M1_PREADY <= 1'b0;
            if (grant_vld) begin
                last_grant <= grant_sel;
                PSEL       <= 1'b1;
                PENABLE    <= 1'b0;
                PADDR      <= grant_sel ? M1_PADDR  : M0_PADDR;
                PPROT      <= grant_sel ? M1_PPROT  : M0_PPROT;
                PWRITE     <= grant_sel ? M1_PWRITE : M0_PWRITE;
                PWDATA     <= grant_sel ? M1_PWDATA : M0_PWDATA;
                PSTRB      <= grant_sel ? M1_PSTRB  : M0_PSTRB;
            end
            if (state == SETUP)
                PENABLE <= 1'b1;
            // Response goes only to the requester recorded at grant time.
            if (done) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                if (last_grant) begin
                    M1_PREADY  <= 1'b1;
                    M1_PRDATA  <= rsp_data;
                    M1_PSLVERR <= rsp_err;
                end else begin
                    M0_PREADY  <= 1'b1;
                    M0_PRDATA  <= rsp_data;
                    M0_PSLVERR <= rsp_err;
                end
            end
        end
    end

endmodule
